// File: rtl/svmscore_capture.sv
// svmscore_capture: sink for the per-window signed SVM score stream.
// Tracks window column/row within a frame, pushes above-threshold scores
// into a detection FIFO and exposes control, status and the FIFO through a
// small Avalon-MM register slave.
module svmscore_capture #(
  parameter int IN_SIZE       = 32,
  parameter int NCOLS         = 10,
  parameter int NROWS         = 44,
  parameter int FIFO_DEPTH    = 16,
  parameter int CLK_PROC_FREQ = 48
) (
  input  logic               clk_proc,
  input  logic               reset_n,
  input  logic               in_fv,
  input  logic               in_dv,
  input  logic [IN_SIZE-1:0] in_data,
  input  logic [1:0]         addr_rel_i,
  input  logic               wr_i,
  input  logic [31:0]        datawr_i,
  input  logic               rd_i,
  output logic [31:0]        datard_o,
  output logic               det_irq_o
);

  localparam int CW = $clog2(NCOLS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [CW-1:0] COL_LAST = CW'(NCOLS - 1);
  localparam logic [6:0]    ROW_END  = 7'(NROWS);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
  localparam logic signed [IN_SIZE-1:0] SAT_MAX = IN_SIZE'(32767);
  localparam logic signed [IN_SIZE-1:0] SAT_MIN = IN_SIZE'(-32768);

  localparam logic [1:0] A_SCR    = 2'd0;
  localparam logic [1:0] A_THRESH = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;
  localparam logic [1:0] A_DET    = 2'd3;

  // registered state
  logic          en_q, clr_q, irq_en_q;
  logic [31:0]   thresh_q;
  logic          ovf_q, ferr_q;
  logic [15:0]   fcnt_q;
  logic [CW-1:0] col_q;
  logic [6:0]    row_q;
  logic          armed_q, fv_q;
  logic [PW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] lvl_q;
  logic [31:0]   datard_q;
  logic [31:0]   mem_q [FIFO_DEPTH];

  // next-state
  logic          en_d, clr_d, irq_en_d;
  logic [31:0]   thresh_d;
  logic          ovf_d, ferr_d;
  logic [15:0]   fcnt_d;
  logic [CW-1:0] col_d;
  logic [6:0]    row_d;
  logic          armed_d;
  logic [PW-1:0] wptr_d, rptr_d;
  logic [LW-1:0] lvl_d;
  logic [31:0]   datard_d;

  // decode
  logic        rd_en, wr_scr, wr_thr, flush;
  logic        fv_rise, fv_fall, dv_ok, beyond, hit;
  logic        full, empty, push, pop, ovf_set;
  logic [15:0] sat;
  logic [31:0] rec, status;

  // Strobe decode, frame edges, detection and FIFO push/pop arbitration.
  // A write wins over a simultaneous read, so a clear can never meet a pop.
  always_comb begin
    rd_en   = rd_i & ~wr_i;
    wr_scr  = wr_i & (addr_rel_i == A_SCR);
    wr_thr  = wr_i & (addr_rel_i == A_THRESH);
    flush   = wr_scr & datawr_i[1];
    fv_rise = in_fv & ~fv_q;
    fv_fall = ~in_fv & fv_q;
    dv_ok   = in_fv & in_dv & armed_q & en_q;
    beyond  = (row_q >= ROW_END);
    hit     = dv_ok & ~beyond & ($signed(in_data) > $signed(thresh_q));
    full    = (lvl_q == LVL_FULL);
    empty   = (lvl_q == '0);
    pop     = rd_en & (addr_rel_i == A_DET) & ~empty;
    push    = hit & ~flush & (~full | pop);
    ovf_set = hit & ~flush & full & ~pop;
  end

  // Detection record: saturated score plus window position.
  always_comb begin
    sat = in_data[15:0];
    if ($signed(in_data) > SAT_MAX)      sat = 16'h7FFF;
    else if ($signed(in_data) < SAT_MIN) sat = 16'h8000;
    rec = {1'b1, row_q, {(8 - CW){1'b0}}, col_q, sat};
  end

  // STATUS word assembly.
  always_comb begin
    status         = '0;
    status[LW-1:0] = lvl_q;
    status[8]      = ovf_q;
    status[9]      = ferr_q;
    status[31:16]  = fcnt_q;
  end

  // Next-state for registers, window counters, frame tracking and FIFO pointers.
  always_comb begin
    en_d     = en_q;
    irq_en_d = irq_en_q;
    clr_d    = flush;
    thresh_d = thresh_q;
    ovf_d    = ovf_q | ovf_set;
    ferr_d   = ferr_q | (dv_ok & beyond);
    fcnt_d   = fcnt_q;
    col_d    = col_q;
    row_d    = row_q;
    armed_d  = armed_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    lvl_d    = lvl_q + LW'(push) - LW'(pop);
    datard_d = datard_q;

    if (wr_scr) begin
      en_d     = datawr_i[0];
      irq_en_d = datawr_i[2];
    end
    if (wr_thr) thresh_d = datawr_i;

    if (fv_rise) begin
      armed_d = 1'b1;
      col_d   = '0;
      row_d   = '0;
    end else if (dv_ok & ~beyond) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_q + 7'd1;
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    if (fv_fall) begin
      armed_d = 1'b0;
      if (armed_q) fcnt_d = fcnt_q + 16'd1;
    end

    if (push) wptr_d = wptr_q + PW'(1);
    if (pop)  rptr_d = rptr_q + PW'(1);

    if (rd_en) begin
      case (addr_rel_i)
        A_SCR:    datard_d = {29'd0, irq_en_q, clr_q, en_q};
        A_THRESH: datard_d = thresh_q;
        A_STATUS: datard_d = status;
        default:  datard_d = empty ? 32'd0 : mem_q[rptr_q];
      endcase
    end

    if (flush) begin
      armed_d = 1'b0;
      fcnt_d  = '0;
      ovf_d   = 1'b0;
      ferr_d  = 1'b0;
      lvl_d   = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end
  end

  // State registers. fv_q resets high so an in_fv still asserted after a
  // mid-frame reset is not mistaken for a new frame start.
  always_ff @(posedge clk_proc) begin
    if (!reset_n) begin
      en_q     <= 1'b0;
      clr_q    <= 1'b0;
      irq_en_q <= 1'b0;
      thresh_q <= '0;
      ovf_q    <= 1'b0;
      ferr_q   <= 1'b0;
      fcnt_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
      armed_q  <= 1'b0;
      fv_q     <= 1'b1;
      wptr_q   <= '0;
      rptr_q   <= '0;
      lvl_q    <= '0;
      datard_q <= '0;
    end else begin
      en_q     <= en_d;
      clr_q    <= clr_d;
      irq_en_q <= irq_en_d;
      thresh_q <= thresh_d;
      ovf_q    <= ovf_d;
      ferr_q   <= ferr_d;
      fcnt_q   <= fcnt_d;
      col_q    <= col_d;
      row_q    <= row_d;
      armed_q  <= armed_d;
      fv_q     <= in_fv;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      lvl_q    <= lvl_d;
      datard_q <= datard_d;
    end
  end

  // FIFO storage; validity is tracked by the level, so no reset is needed.
  always_ff @(posedge clk_proc) begin
    if (push) mem_q[wptr_q] <= rec;
  end

  assign datard_o  = datard_q;
  assign det_irq_o = irq_en_q & (lvl_q != '0);

endmodule

// File: tb/tb_svmscore_capture.sv
module tb_svmscore_capture;

  logic        clk_proc = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_fv = 1'b0;
  logic        in_dv = 1'b0;
  logic [31:0] in_data = '0;
  logic [1:0]  addr_rel_i = '0;
  logic        wr_i = 1'b0;
  logic [31:0] datawr_i = '0;
  logic        rd_i = 1'b0;
  logic [31:0] datard_o;
  logic        det_irq_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [31:0] det_q[$];
  logic signed [31:0] thr_m = '0;
  logic [31:0] sc [0:511];

  typedef struct {
    logic [31:0] score;
    logic [31:0] thr;
    logic [31:0] exp_det;
  } vec_t;

  always #5 clk_proc = ~clk_proc;

  svmscore_capture dut (
    .clk_proc   (clk_proc),
    .reset_n    (reset_n),
    .in_fv      (in_fv),
    .in_dv      (in_dv),
    .in_data    (in_data),
    .addr_rel_i (addr_rel_i),
    .wr_i       (wr_i),
    .datawr_i   (datawr_i),
    .rd_i       (rd_i),
    .datard_o   (datard_o),
    .det_irq_o  (det_irq_o)
  );

  task automatic tick();
    @(posedge clk_proc);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr_rel_i = a;
    datawr_i   = d;
    wr_i       = 1'b1;
    tick();
    wr_i = 1'b0;
    if (a == 2'd1) thr_m = d;
    if (a == 2'd0 && d[1]) det_q.delete();
  endtask

  // expected value queued at issue, compared when the registered data appears
  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
    addr_rel_i = a;
    rd_i       = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    tick();
    rd_i = 1'b0;
    check(name_q.pop_front(), datard_o, exp_q.pop_front());
  endtask

  task automatic rd_det(input string nm);
    logic [31:0] e;
    e = (det_q.size() != 0) ? det_q.pop_front() : 32'd0;
    rd(2'd3, e, nm);
  endtask

  function automatic logic [15:0] sat16(input logic signed [31:0] s);
    if (s > 32767)  return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  task automatic model_dv(input int idx, input logic [31:0] score);
    if (idx < 440 && $signed(score) > thr_m && det_q.size() < 16)
      det_q.push_back({1'b1, 7'(idx / 10), 8'(idx % 10), sat16(score)});
  endtask

  task automatic fill(input logic [31:0] v);
    for (int i = 0; i < 512; i++) sc[i] = v;
  endtask

  // one frame of n back-to-back scores; optional DET read on pulse rd_at
  task automatic frame(input int n, input int rd_at);
    in_fv = 1'b1;
    tick();
    tick();
    for (int i = 0; i < n; i++) begin
      in_dv   = 1'b1;
      in_data = sc[i];
      if (i == rd_at) begin
        addr_rel_i = 2'd3;
        rd_i       = 1'b1;
        exp_q.push_back((det_q.size() != 0) ? det_q.pop_front() : 32'd0);
        name_q.push_back("rd_with_push");
      end
      model_dv(i, sc[i]);
      tick();
      if (i == rd_at) begin
        rd_i = 1'b0;
        check(name_q.pop_front(), datard_o, exp_q.pop_front());
      end
    end
    in_dv = 1'b0;
    in_fv = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[7];
    tbl[0] = '{32'h0010_0000, 32'd100,        32'h8000_7FFF};
    tbl[1] = '{-32'sd200000,  -32'sd300000,   32'h8000_8000};
    tbl[2] = '{32'd32767,     32'd0,          32'h8000_7FFF};
    tbl[3] = '{-32'sd32768,   -32'sd40000,    32'h8000_8000};
    tbl[4] = '{-32'sd5,       -32'sd10,       32'h8000_FFFB};
    tbl[5] = '{32'd100,       32'd100,        32'h0000_0000};
    tbl[6] = '{32'd32768,     32'd32767,      32'h8000_7FFF};

    // reset state
    tick(); tick(); tick();
    reset_n = 1'b1;
    tick();
    check("rst_datard", datard_o, 32'd0);
    check("rst_irq", {31'd0, det_irq_o}, 32'd0);
    rd(2'd0, 32'd0, "rst_scr");
    rd(2'd1, 32'd0, "rst_thresh");
    rd(2'd2, 32'd0, "rst_status");
    rd(2'd3, 32'd0, "rst_det_empty");

    // single detection at row 3 col 7
    wr(2'd1, 32'd100);
    wr(2'd0, 32'h1);
    fill(32'd0);
    sc[37] = 32'd500;
    frame(440, -1);
    rd(2'd2, 32'h0001_0001, "t1_status");
    rd(2'd3, 32'h8307_01F4, "t1_det");
    det_q.delete();
    tick(); tick(); tick();
    check("t1_datard_hold", datard_o, 32'h8307_01F4);
    rd(2'd2, 32'h0001_0000, "t1_status_after_pop");

    // saturation and strict-greater threshold, one-score frames
    for (int k = 0; k < 7; k++) begin
      wr(2'd1, tbl[k].thr);
      rd(2'd1, tbl[k].thr, "t2_thresh_rb");
      fill(32'd0);
      sc[0] = tbl[k].score;
      frame(1, -1);
      rd(2'd3, tbl[k].exp_det, "t2_sat_det");
      det_q.delete();
    end

    // overflow: 20 detections into a 16-deep FIFO
    wr(2'd0, 32'h3);
    rd(2'd0, 32'h3, "t6a_scr_clr_bit");
    rd(2'd0, 32'h1, "t6a_scr_selfclear");
    wr(2'd1, 32'd100);
    fill(32'd0);
    for (int i = 0; i < 20; i++) sc[i * 21] = 32'd200 + 32'(i);
    frame(440, -1);
    rd(2'd2, 32'h0001_0110, "t3_status");
    wr(2'd0, 32'h5);
    check("t3_irq", {31'd0, det_irq_o}, 32'd1);
    for (int i = 0; i < 16; i++) rd_det("t3_det_order");
    rd(2'd3, 32'd0, "t3_det_17th");
    check("t3_irq_empty", {31'd0, det_irq_o}, 32'd0);

    // full FIFO with a read in the same cycle as a push
    wr(2'd0, 32'h3);
    fill(32'd0);
    for (int i = 0; i < 16; i++) sc[i] = 32'd300 + 32'(i);
    sc[20] = 32'd999;
    frame(440, 20);
    rd(2'd2, 32'h0001_0010, "t4_status");
    for (int i = 0; i < 16; i++) rd_det("t4_det_order");
    rd(2'd2, 32'h0001_0000, "t4_status_empty");

    // framing error on the 441st pulse, then clear
    wr(2'd0, 32'h3);
    fill(32'd0);
    sc[439] = 32'd900;
    sc[440] = 32'd1000;
    frame(441, -1);
    rd(2'd2, 32'h0001_0201, "t6_status");
    wr(2'd0, 32'h5);
    check("t6_irq", {31'd0, det_irq_o}, 32'd1);
    wr(2'd0, 32'h2);
    rd(2'd2, 32'd0, "t6_status_clr");
    rd(2'd3, 32'd0, "t6_det_clr");
    check("t6_irq_clr", {31'd0, det_irq_o}, 32'd0);

    // reset at row 10 mid-frame; rest of frame ignored
    wr(2'd1, 32'd100);
    wr(2'd0, 32'h1);
    in_fv = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 100; i++) begin
      in_dv = 1'b1; in_data = 32'd0; tick();
    end
    in_dv   = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    det_q.delete();
    thr_m = '0;
    wr(2'd1, 32'd100);
    wr(2'd0, 32'h1);
    for (int i = 100; i < 440; i++) begin
      in_dv = 1'b1; in_data = 32'd500; tick();
    end
    in_dv = 1'b0;
    in_fv = 1'b0;
    tick();
    tick();
    rd(2'd2, 32'd0, "t5_status_ignored");
    fill(32'd0);
    sc[439] = 32'd500;
    frame(440, -1);
    rd(2'd2, 32'h0001_0001, "t5_status_next");
    rd(2'd3, 32'hAB09_01F4, "t5_det_last_window");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
